// File: rtl/sram_burst_master_if.sv
// Bus bundle for sram_burst_master: command port, read/write word streams,
// memory-side request/response and status flags.
interface sram_burst_master_if #(
    parameter int unsigned DATA  = 32,
    parameter int unsigned ADDR  = 23,
    parameter int unsigned LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ADDR-1:0]  cmd_rd_addr;
    logic [ADDR-1:0]  cmd_wr_addr;
    logic [LEN_W-1:0] cmd_len;

    logic [DATA-1:0]  src_data;
    logic             src_valid;
    logic             src_ready;

    logic [DATA-1:0]  snk_data;
    logic             snk_valid;
    logic             snk_ready;

    logic [ADDR-1:0]  address;
    logic             read;
    logic             write;
    logic [DATA-1:0]  writedata;
    logic [DATA-1:0]  readdata;
    logic             readdatavalid;
    logic             waitrequest;

    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  cmd_valid, cmd_rd_addr, cmd_wr_addr, cmd_len,
        input  src_ready, snk_data, snk_valid,
        input  readdata, readdatavalid, waitrequest,
        output cmd_ready, src_data, src_valid, snk_ready,
        output address, read, write, writedata,
        output busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_rd_addr, cmd_wr_addr, cmd_len,
        output src_ready, snk_data, snk_valid,
        output readdata, readdatavalid, waitrequest,
        input  cmd_ready, src_data, src_valid, snk_ready,
        input  address, read, write, writedata,
        input  busy, done, err
    );
endinterface

// File: rtl/sram_burst_master.sv
// Burst mover: pipelined reads from SRAM into a word stream, then one-at-a-time
// writes from an inbound word stream back to SRAM, with a read-data FIFO.
module sram_burst_master #(
    parameter int unsigned DATA       = 32,
    parameter int unsigned ADDR       = 23,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    sram_burst_master_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_DRAIN, WR_FETCH, WR_HOLD, FIN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  written_q, written_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [DATA-1:0]   fifo_q [FIFO_DEPTH];
    logic              err_q, err_d;

    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [DATA-1:0]   wdata_q, wdata_d;
    logic              src_valid_q, src_valid_d;
    logic              snk_ready_q, snk_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic              push, pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            written_q   <= '0;
            outst_q     <= '0;
            cnt_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            err_q       <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            src_valid_q <= 1'b0;
            snk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            written_q   <= written_d;
            outst_q     <= outst_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            src_valid_q <= src_valid_d;
            snk_ready_q <= snk_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Storage only; occupancy lives in cnt_q/head_q/tail_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= bus.readdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        written_d = written_q;
        wdata_d   = wdata_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_d     = err_q;

        // Data with nothing in flight is stray: drop it and flag.
        push = bus.readdatavalid && (outst_q != '0);
        pop  = src_valid_q && bus.src_ready;
        if (bus.readdatavalid && (outst_q == '0)) begin
            err_d = 1'b1;
        end
        outst_d = outst_q + CNT_W'(read_q) - CNT_W'(push);
        cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    rd_ptr_d  = bus.cmd_rd_addr;
                    wr_ptr_d  = bus.cmd_wr_addr;
                    len_d     = bus.cmd_len;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = (bus.cmd_len == '0) ? FIN : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (read_q) begin
                    rd_ptr_d = rd_ptr_q + ADDR'(1);
                    issued_d = issued_q + LEN_W'(1);
                end
                if (issued_q == len_q) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = WR_FETCH;
                end
            end
            WR_FETCH: begin
                if (bus.snk_valid) begin
                    wdata_d = bus.snk_data;
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: begin
                if (!bus.waitrequest) begin
                    wr_ptr_d  = wr_ptr_q + ADDR'(1);
                    written_d = written_q + LEN_W'(1);
                    state_d   = ((written_q + LEN_W'(1)) == len_q) ? FIN : WR_FETCH;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Issue only while FIFO space covers every word already in flight.
        read_d      = (state_d == RD_ISSUE) && (issued_d < len_d) &&
                      ((SUM_W'(cnt_d) + SUM_W'(outst_d)) < SUM_W'(FIFO_DEPTH));
        write_d     = (state_d == WR_HOLD);
        addr_d      = read_d ? rd_ptr_d : (write_d ? wr_ptr_d : '0);
        src_valid_d = (cnt_d != '0);
        snk_ready_d = (state_d == WR_FETCH);
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
        done_d      = (state_q == FIN);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.src_data  = fifo_q[head_q];
    assign bus.src_valid = src_valid_q;
    assign bus.snk_ready = snk_ready_q;
    assign bus.address   = addr_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.writedata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sram_burst_master.sv
// Self-checking bench for sram_burst_master with a behavioural SRAM, stream
// producer/consumer and a transaction-level scoreboard.
module tb_sram_burst_master;
    localparam int unsigned DATA  = 32;
    localparam int unsigned ADDR  = 23;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_burst_master_if #(.DATA(DATA), .ADDR(ADDR), .LEN_W(LEN_W)) bus ();

    sram_burst_master #(.DATA(DATA), .ADDR(ADDR), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 2;
    int wait_n = 3;
    int src_mode = 1;
    int snk_mode = 0;
    int stray_req = 0;

    logic [DATA-1:0] snk_q[$];
    logic [ADDR-1:0] rd_log[$];
    int              rd_cyc[$];
    logic [DATA-1:0] src_log[$];
    logic [ADDR-1:0] wr_alog[$];
    logic [DATA-1:0] wr_dlog[$];
    int              wr_hold[$];
    int              done_cyc[$];
    int              resp_due[$];
    logic [DATA-1:0] resp_dat[$];
    int both_cnt = 0, snk_bad = 0, hold_bad = 0, occ = 0, max_occ = 0;
    int wcyc = 0, snk_idx = 0, wr_cyc_total = 0, stray_done = 0;
    logic [ADDR-1:0] hold_a;
    logic [DATA-1:0] hold_d;

    function automatic logic [DATA-1:0] mem_word(input logic [ADDR-1:0] a);
        return (DATA'(a) * DATA'(32'h9E37_79B1)) ^ DATA'(32'h5A5A_C3C3);
    endfunction

    function automatic logic [ADDR-1:0] addr_at(input logic [ADDR-1:0] base, input int i);
        return ADDR'((64'(base) + 64'(i)) % (64'd1 << ADDR));
    endfunction

    // Environment: SRAM with fixed read latency, waitrequest stretcher, stream ends.
    initial begin
        bus.readdatavalid = 1'b0; bus.readdata = '0; bus.waitrequest = 1'b0;
        bus.src_ready = 1'b0; bus.snk_valid = 1'b0; bus.snk_data = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                resp_due.delete(); resp_dat.delete();
                occ = 0; wcyc = 0; snk_idx = snk_q.size();
                bus.readdatavalid = 1'b0; bus.waitrequest = 1'b0;
                bus.src_ready = 1'b0; bus.snk_valid = 1'b0;
                continue;
            end
            if (bus.read) begin
                resp_due.push_back(cyc + lat);
                resp_dat.push_back(mem_word(bus.address));
                rd_log.push_back(bus.address);
                rd_cyc.push_back(cyc);
                occ++;
                if (occ > max_occ) max_occ = occ;
                if (bus.write) both_cnt++;
            end
            if (stray_done != stray_req) begin
                bus.readdatavalid = 1'b1; bus.readdata = DATA'(32'hDEAD_BEEF);
                stray_done++;
            end else if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
                bus.readdatavalid = 1'b1; bus.readdata = resp_dat[0];
                void'(resp_due.pop_front()); void'(resp_dat.pop_front());
            end else begin
                bus.readdatavalid = 1'b0; bus.readdata = DATA'($urandom);
            end
            case (src_mode)
                0:       bus.src_ready = 1'b0;
                1:       bus.src_ready = 1'b1;
                default: bus.src_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.src_valid && bus.src_ready) begin
                src_log.push_back(bus.src_data);
                occ--;
            end
            if (bus.write) begin
                wr_cyc_total++;
                wcyc++;
                if (wcyc == 1) begin
                    hold_a = bus.address; hold_d = bus.writedata;
                end else if (hold_a !== bus.address || hold_d !== bus.writedata) begin
                    hold_bad++;
                end
                if (wcyc <= wait_n) begin
                    bus.waitrequest = 1'b1;
                end else begin
                    bus.waitrequest = 1'b0;
                    wr_alog.push_back(bus.address);
                    wr_dlog.push_back(bus.writedata);
                    wr_hold.push_back(wcyc);
                    wcyc = 0;
                end
            end else begin
                bus.waitrequest = 1'($urandom_range(0, 1));
            end
            if (snk_idx < snk_q.size() && (snk_mode == 0 || $urandom_range(0, 1) == 1)) begin
                bus.snk_valid = 1'b1; bus.snk_data = snk_q[snk_idx];
            end else begin
                bus.snk_valid = 1'b0; bus.snk_data = DATA'($urandom);
            end
            if (bus.snk_valid && bus.snk_ready) snk_idx++;
            if (bus.snk_ready && bus.write) snk_bad++;
            if (bus.done) done_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic send_cmd(input logic [ADDR-1:0] ra, input logic [ADDR-1:0] wa,
                            input int len, output int hs, output bit ok);
        int n;
        n = 0;
        bus.cmd_rd_addr = ra; bus.cmd_wr_addr = wa;
        bus.cmd_len = LEN_W'(len); bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            step(1); n++;
        end
        hs = cyc;
        ok = (n < 100);
        step(1);
        bus.cmd_valid = 1'b0;
        bus.cmd_rd_addr = ADDR'($urandom); bus.cmd_wr_addr = ADDR'($urandom);
        bus.cmd_len = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int n;
        n = 0;
        while (done_cyc.size() <= d0 && n < 3000) begin
            step(1); n++;
        end
        ok = (done_cyc.size() > d0);
    endtask

    task automatic wait_src(input int target, output bit ok);
        int n;
        n = 0;
        while (src_log.size() < target && n < 3000) begin
            step(1); n++;
        end
        ok = (src_log.size() >= target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_rd_addr = '0; bus.cmd_wr_addr = '0; bus.cmd_len = '0;
        step(3);
        checks++;
        if ({bus.read, bus.write, bus.src_valid, bus.snk_ready, bus.busy, bus.done, bus.err} !== 7'b0) begin
            $display("FAIL reset_flags got=%b want=0000000",
                     {bus.read, bus.write, bus.src_valid, bus.snk_ready, bus.busy, bus.done, bus.err});
            errors++;
        end
        checks++;
        if (bus.address !== '0 || bus.writedata !== '0) begin
            $display("FAIL reset_buses address=%h writedata=%h want 0", bus.address, bus.writedata);
            errors++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
            errors++;
        end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        int rd0, s0, w0, d0, hs;
        bit ok;
        logic [DATA-1:0] exp_w[$];
        lat = 2; wait_n = 3; src_mode = 1; snk_mode = 0;
        rd0 = rd_log.size(); s0 = src_log.size(); w0 = wr_alog.size(); d0 = done_cyc.size();
        for (int i = 0; i < 4; i++) begin
            exp_w.push_back(DATA'($urandom)); snk_q.push_back(exp_w[i]);
        end
        send_cmd(23'h10, 23'h100, 4, hs, ok);
        wait_done(d0, ok);
        checks++;
        if (!ok) begin $display("FAIL basic_done_timeout done_count=%0d want>%0d", done_cyc.size(), d0); errors++; end
        wait_src(s0 + 4, ok);
        step(5);
        checks++;
        if (rd_log.size() - rd0 !== 4) begin
            $display("FAIL basic_read_count got=%0d want=4", rd_log.size() - rd0); errors++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_log[rd0+i] !== ADDR'(32'h10 + i) || rd_cyc[rd0+i] !== rd_cyc[rd0] + i) begin
                    $display("FAIL basic_read_%0d addr=%h cyc=%0d want addr=%h cyc=%0d",
                             i, rd_log[rd0+i], rd_cyc[rd0+i], 32'h10 + i, rd_cyc[rd0] + i);
                    errors++;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (src_log.size() <= s0 + i || src_log[s0+i] !== mem_word(ADDR'(32'h10 + i))) begin
                $display("FAIL basic_src_%0d got=%h want=%h", i,
                         (src_log.size() > s0 + i) ? src_log[s0+i] : 'x, mem_word(ADDR'(32'h10 + i)));
                errors++;
            end
        end
        checks++;
        if (wr_alog.size() - w0 !== 4) begin
            $display("FAIL basic_write_count got=%0d want=4", wr_alog.size() - w0); errors++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_alog[w0+i] !== ADDR'(32'h100 + i) || wr_dlog[w0+i] !== exp_w[i] || wr_hold[w0+i] !== 4) begin
                    $display("FAIL basic_write_%0d addr=%h data=%h hold=%0d want %h %h 4",
                             i, wr_alog[w0+i], wr_dlog[w0+i], wr_hold[w0+i], 32'h100 + i, exp_w[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (done_cyc.size() - d0 !== 1) begin
            $display("FAIL basic_done_pulses got=%0d want=1", done_cyc.size() - d0); errors++;
        end
    endtask

    task automatic test_backpressure();
        int rd0, s0, d0, hs;
        bit ok;
        lat = 3; wait_n = 0; src_mode = 0; snk_mode = 1;
        rd0 = rd_log.size(); s0 = src_log.size(); d0 = done_cyc.size();
        for (int i = 0; i < 20; i++) snk_q.push_back(DATA'($urandom));
        send_cmd(23'h2000, 23'h3000, 20, hs, ok);
        step(40);
        checks++;
        if (rd_log.size() - rd0 !== DEPTH || src_log.size() !== s0) begin
            $display("FAIL bp_stall reads=%0d pops=%0d want reads=%0d pops=0",
                     rd_log.size() - rd0, src_log.size() - s0, DEPTH);
            errors++;
        end
        checks++;
        if (max_occ !== DEPTH) begin
            $display("FAIL bp_occupancy max=%0d want=%0d", max_occ, DEPTH); errors++;
        end
        src_mode = 2;
        wait_done(d0, ok);
        wait_src(s0 + 20, ok);
        checks++;
        if (!ok || rd_log.size() - rd0 !== 20) begin
            $display("FAIL bp_totals reads=%0d words=%0d want 20 20", rd_log.size() - rd0, src_log.size() - s0);
            errors++;
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rd_log[rd0+i] !== addr_at(23'h2000, i) || src_log[s0+i] !== mem_word(addr_at(23'h2000, i))) begin
                    $display("FAIL bp_word_%0d addr=%h data=%h want %h %h", i, rd_log[rd0+i], src_log[s0+i],
                             addr_at(23'h2000, i), mem_word(addr_at(23'h2000, i)));
                    errors++;
                end
            end
        end
        checks++;
        if (max_occ > DEPTH) begin
            $display("FAIL bp_overflow max=%0d limit=%0d", max_occ, DEPTH); errors++;
        end
    endtask

    task automatic test_wrap();
        int rd0, w0, d0, hs;
        bit ok;
        logic [ADDR-1:0] exp_r[3];
        logic [ADDR-1:0] exp_a[3];
        exp_r[0] = 23'h7FFFFE; exp_r[1] = 23'h7FFFFF; exp_r[2] = 23'h000000;
        exp_a[0] = 23'h7FFFFF; exp_a[1] = 23'h000000; exp_a[2] = 23'h000001;
        lat = int'($urandom_range(1, 4)); wait_n = int'($urandom_range(0, 4)); src_mode = 2; snk_mode = 1;
        rd0 = rd_log.size(); w0 = wr_alog.size(); d0 = done_cyc.size();
        for (int i = 0; i < 3; i++) snk_q.push_back(DATA'($urandom));
        send_cmd(23'h7FFFFE, 23'h7FFFFF, 3, hs, ok);
        wait_done(d0, ok);
        checks++;
        if (!ok || rd_log.size() - rd0 !== 3 || wr_alog.size() - w0 !== 3) begin
            $display("FAIL wrap_counts reads=%0d writes=%0d want 3 3", rd_log.size() - rd0, wr_alog.size() - w0);
            errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd_log[rd0+i] !== exp_r[i] || wr_alog[w0+i] !== exp_a[i] || wr_hold[w0+i] !== wait_n + 1) begin
                    $display("FAIL wrap_%0d rd=%h wr=%h hold=%0d want %h %h %0d", i, rd_log[rd0+i],
                             wr_alog[w0+i], wr_hold[w0+i], exp_r[i], exp_a[i], wait_n + 1);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int rd0, w0, d0, hs;
        bit ok;
        step(10);
        rd0 = rd_log.size(); w0 = wr_cyc_total; d0 = done_cyc.size();
        send_cmd(23'h55, 23'h66, 0, hs, ok);
        wait_done(d0, ok);
        step(4);
        checks++;
        if (!ok || done_cyc.size() - d0 !== 1 || done_cyc[d0] - hs !== 2) begin
            $display("FAIL zero_done pulses=%0d delay=%0d want 1 pulse at 2", done_cyc.size() - d0,
                     ok ? done_cyc[d0] - hs : -1);
            errors++;
        end
        checks++;
        if (rd_log.size() !== rd0 || wr_cyc_total !== w0) begin
            $display("FAIL zero_traffic reads=%0d write_cycles=%0d want 0 0", rd_log.size() - rd0, wr_cyc_total - w0);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int rd0, s0, w0, d0, hs;
        bit ok;
        logic [ADDR-1:0] exp_ra[$];
        logic [ADDR-1:0] exp_wa[$];
        logic [DATA-1:0] exp_wd[$];
        int exp_h[$];
        logic [ADDR-1:0] ra, wa;
        int len;
        src_mode = 2; snk_mode = 1;
        rd0 = rd_log.size(); s0 = src_log.size(); w0 = wr_alog.size(); d0 = done_cyc.size();
        for (int c = 0; c < 5; c++) begin
            ra = ADDR'($urandom); wa = ADDR'($urandom);
            if (c == 2) ra = 23'h7FFFFA;
            len = int'($urandom_range(1, 12));
            lat = int'($urandom_range(1, 4)); wait_n = int'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                exp_ra.push_back(addr_at(ra, i)); exp_wa.push_back(addr_at(wa, i));
                exp_wd.push_back(DATA'($urandom)); snk_q.push_back(exp_wd[exp_wd.size()-1]);
                exp_h.push_back(wait_n + 1);
            end
            send_cmd(ra, wa, len, hs, ok);
            wait_done(d0 + c, ok);
            checks++;
            if (!ok) begin $display("FAIL b2b_done_timeout cmd=%0d done_count=%0d", c, done_cyc.size() - d0); errors++; end
        end
        wait_src(s0 + exp_ra.size(), ok);
        checks++;
        if (rd_log.size() - rd0 !== exp_ra.size() || src_log.size() - s0 !== exp_ra.size() ||
            wr_alog.size() - w0 !== exp_wa.size()) begin
            $display("FAIL b2b_counts reads=%0d words=%0d writes=%0d want %0d", rd_log.size() - rd0,
                     src_log.size() - s0, wr_alog.size() - w0, exp_ra.size());
            errors++;
        end else begin
            for (int i = 0; i < exp_ra.size(); i++) begin
                checks++;
                if (rd_log[rd0+i] !== exp_ra[i] || src_log[s0+i] !== mem_word(exp_ra[i]) ||
                    wr_alog[w0+i] !== exp_wa[i] || wr_dlog[w0+i] !== exp_wd[i] || wr_hold[w0+i] !== exp_h[i]) begin
                    $display("FAIL b2b_item_%0d rd=%h src=%h wa=%h wd=%h hold=%0d want %h %h %h %h %0d", i,
                             rd_log[rd0+i], src_log[s0+i], wr_alog[w0+i], wr_dlog[w0+i], wr_hold[w0+i],
                             exp_ra[i], mem_word(exp_ra[i]), exp_wa[i], exp_wd[i], exp_h[i]);
                    errors++;
                end
            end
        end
        checks++;
        if (done_cyc.size() - d0 !== 5 || bus.err !== 1'b0) begin
            $display("FAIL b2b_status done=%0d err=%b want 5 0", done_cyc.size() - d0, bus.err); errors++;
        end
        checks++;
        if (both_cnt !== 0 || snk_bad !== 0 || hold_bad !== 0 || max_occ > DEPTH) begin
            $display("FAIL protocol both=%0d snk_ready_in_write=%0d hold_changes=%0d max_occ=%0d want 0 0 0 <=%0d",
                     both_cnt, snk_bad, hold_bad, max_occ, DEPTH);
            errors++;
        end
    endtask

    task automatic test_reset_abort();
        int hs, n, wcnt, rcnt, s0;
        bit ok;
        lat = 2; wait_n = 20; src_mode = 1; snk_mode = 0;
        for (int i = 0; i < 3; i++) snk_q.push_back(DATA'($urandom));
        send_cmd(23'h400, 23'h500, 3, hs, ok);
        n = 0;
        while (bus.write !== 1'b1 && n < 200) begin step(1); n++; end
        checks++;
        if (bus.write !== 1'b1) begin $display("FAIL abort_no_write write=%b want 1", bus.write); errors++; end
        reset = 1'b1;
        step(1);
        checks++;
        if (bus.write !== 1'b0 || bus.read !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            $display("FAIL abort_outputs write=%b read=%b cmd_ready=%b busy=%b want 0 0 1 0",
                     bus.write, bus.read, bus.cmd_ready, bus.busy);
            errors++;
        end
        reset = 1'b0;
        wcnt = wr_cyc_total; rcnt = rd_log.size(); s0 = src_log.size();
        step(6);
        checks++;
        if (wr_cyc_total !== wcnt || rd_log.size() !== rcnt || bus.err !== 1'b0) begin
            $display("FAIL abort_quiet write_cycles=%0d reads=%0d err=%b want 0 0 0",
                     wr_cyc_total - wcnt, rd_log.size() - rcnt, bus.err);
            errors++;
        end
        stray_req++;
        step(4);
        checks++;
        if (bus.err !== 1'b1 || bus.src_valid !== 1'b0 || src_log.size() !== s0) begin
            $display("FAIL stray_data err=%b src_valid=%b words=%0d want 1 0 0",
                     bus.err, bus.src_valid, src_log.size() - s0);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
